avr_sample_spi_master: RTL and testbench

SPI master that drives the FPGA's ADC-sample SPI link from the other end: it frames one 10-bit sample plus 4-bit channel number into the two-byte frame the sample receiver decodes, and shifts it out on ss/sck/mosi. It is used for FPGA-to-FPGA sample bridging and as the bus-functional driver in `avr_interface` benches. A frame is started by a one-cycle request. MISO bits are captured during the frame and returned alongside the completion pulse.

---
 rtl/avr_sample_spi_master_if.sv | 38 +++
 rtl/avr_sample_spi_master.sv | 147 ++++++++++++++
 tb/tb_avr_sample_spi_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_sample_spi_master_if.sv
// avr_sample_spi_master_if
// Bundles the request/response side and the SPI pins of the sample SPI master.
//
// Handshake: new_sample acts as "valid" and !busy acts as "ready". A frame is
// accepted on the clk edge where new_sample=1 and busy=0. A request seen
// while busy=1 is dropped, not held. done is a one-cycle completion pulse.
// miso_data is valid in the done cycle and holds until the next done.
//
// Signals:
//   sample[9:0], sample_channel[3:0]  frame payload, latched on acceptance
//   new_sample                        start request
//   busy                              frame or inter-frame gap in progress
//   done, miso_data[15:0]             completion pulse and captured MISO bits
//   spi_ss, spi_sck, spi_mosi         SPI outputs (ss active low, sck idle low)
//   spi_miso                          SPI input
// Modports: master (the SPI master block), slave (whatever drives it).
interface avr_sample_spi_master_if;
  logic [9:0]  sample;
  logic [3:0]  sample_channel;
  logic        new_sample;
  logic        busy;
  logic        done;
  logic [15:0] miso_data;
  logic        spi_ss;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  sample, sample_channel, new_sample, spi_miso,
    output busy, done, miso_data, spi_ss, spi_sck, spi_mosi
  );

  modport slave (
    output sample, sample_channel, new_sample, spi_miso,
    input  busy, done, miso_data, spi_ss, spi_sck, spi_mosi
  );
endinterface

// File: rtl/avr_sample_spi_master.sv
// avr_sample_spi_master
// SPI mode-0 master that frames a 10-bit sample and a 4-bit channel number
// into two bytes, {sample[7:0]} then {channel, 2'b00, sample[9:8]}, and
// shifts them out MSB first under one continuous ss-low period. MISO bits
// are captured on sck rising edges and presented with the done pulse.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        avr_sample_spi_master_if.master (request, status, SPI pins)
//   state_dbg  current FSM state (0 IDLE, 1 SETUP, 2 SHIFT, 3 GAP)
//
// Parameters:
//   CLK_DIV   clk cycles per sck half-period (>= 1)
//   SS_GAP    clk cycles ss stays high after a frame (>= 1)
//   CTR_SIZE  phase counter width, 2^CTR_SIZE > max(CLK_DIV, SS_GAP)
module avr_sample_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int SS_GAP   = 8,
  parameter int CTR_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  avr_sample_spi_master_if.master        bus,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CTR_SIZE-1:0] DIV_LAST = CTR_SIZE'(CLK_DIV - 1);
  localparam logic [CTR_SIZE-1:0] GAP_LAST = CTR_SIZE'(SS_GAP - 1);

  state_t              state_q, state_d;
  logic [CTR_SIZE-1:0] cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  // sck_q is both the pin and the half-period phase: 1 = high phase.
  logic                sck_q, sck_d;
  logic [15:0]         tx_q, tx_d;
  logic [15:0]         rx_q, rx_d;
  logic [15:0]         miso_data_q, miso_data_d;
  logic                done_q, done_d;
  logic                div_end;
  logic                in_frame;

  assign div_end  = (cnt_q == DIV_LAST);
  assign in_frame = (state_q == SETUP) || (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    sck_d       = sck_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.new_sample) begin
          state_d = SETUP;
          tx_d    = {bus.sample[7:0], bus.sample_channel, 2'b00, bus.sample[9:8]};
        end
      end

      SETUP: begin
        // End of setup is the first sck rising edge: capture bit 0 of MISO.
        if (div_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[14:0], bus.spi_miso};
        end
      end

      SHIFT: begin
        if (div_end) begin
          cnt_d = '0;
          if (sck_q) begin
            // Falling edge: present the next MOSI bit. After the 16th fall
            // the register is all zeros, so mosi idles low during ss hold.
            sck_d = 1'b0;
            tx_d  = {tx_q[14:0], 1'b0};
          end else if (bit_q == 4'd15) begin
            // Low phase of the last bit doubles as ss hold time.
            state_d     = GAP;
            done_d      = 1'b1;
            miso_data_d = rx_q;
          end else begin
            bit_d = bit_q + 4'd1;
            sck_d = 1'b1;
            rx_d  = {rx_q[14:0], bus.spi_miso};
          end
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.spi_ss    = ~in_frame;
  assign bus.spi_sck   = sck_q;
  assign bus.spi_mosi  = in_frame ? tx_q[15] : 1'b0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.miso_data = miso_data_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_avr_sample_spi_master.sv
`timescale 1ns/1ps
module tb_avr_sample_spi_master;

  localparam int C_A      = 4;
  localparam int G_A      = 8;
  localparam int C_B      = 1;
  localparam int G_B      = 1;
  localparam int SS_LOW_A = 33 * C_A;
  localparam int BUSY_A   = 33 * C_A + G_A;
  localparam int SS_LOW_B = 33 * C_B;
  localparam int PERIOD_B = 33 * C_B + G_B + 1;
  localparam int HELD_B   = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  avr_sample_spi_master_if bus_a();
  avr_sample_spi_master_if bus_b();
  logic [1:0] state_dbg_a;
  logic [1:0] state_dbg_b;

  avr_sample_spi_master #(.CLK_DIV(C_A), .SS_GAP(G_A), .CTR_SIZE(4)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .state_dbg(state_dbg_a)
  );

  avr_sample_spi_master #(.CLK_DIV(C_B), .SS_GAP(G_B), .CTR_SIZE(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .state_dbg(state_dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];   // expected MOSI frames, in order
  logic [15:0] resp_q[$];  // MISO words the slave model returns
  int exp_frames_a = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: the two-byte frame as the receiver expects it on the wire.
  function automatic logic [15:0] frame_of(input logic [9:0] s, input logic [3:0] ch);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = s[7:0];
    b1 = {ch, 2'b00, s[9:8]};
    return {b0, b1};
  endfunction

  // ---------------- monitor + slave model, instance A ----------------
  int          cyc_a = 0;
  logic        p_ss = 1'b1, p_sck = 1'b0, p_busy = 1'b0, p_mosi = 1'b0;
  int          t_fall = 0, t_rise = 0, rises = 0, low_len = 0, busy_len = 0;
  logic [15:0] mosi_cap = '0;
  logic [15:0] cur_resp = '0;
  int          frames_a = 0, dones_a = 0, proto_bad_a = 0;

  always @(posedge clk) begin
    logic ss_fall, ss_rise, sck_rise, sck_fall, busy_fall;
    #1;
    cyc_a++;
    if (rst_a) begin
      bus_a.spi_miso = 1'b0;
      busy_len = 0;
      low_len  = 0;
      rises    = 0;
    end else begin
      ss_fall   = p_ss && !bus_a.spi_ss;
      ss_rise   = !p_ss && bus_a.spi_ss;
      sck_rise  = !p_sck && bus_a.spi_sck;
      sck_fall  = p_sck && !bus_a.spi_sck;
      busy_fall = p_busy && !bus_a.busy;

      if (ss_fall) begin
        t_fall   = cyc_a;
        rises    = 0;
        low_len  = 0;
        mosi_cap = '0;
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
        bus_a.spi_miso = cur_resp[15];
      end
      if (!bus_a.spi_ss) low_len++;
      if (bus_a.busy) busy_len++;
      if (bus_a.done) dones_a++;

      // Idle pins must be quiet; mosi may only move at sck falls.
      if (bus_a.spi_ss && (bus_a.spi_sck || bus_a.spi_mosi)) proto_bad_a++;
      if (!bus_a.spi_ss && !p_ss && (bus_a.spi_mosi != p_mosi) && !sck_fall) proto_bad_a++;

      if (sck_rise) begin
        if (rises == 0) check("first_rise_delay", cyc_a - t_fall, C_A);
        else            check("rise_spacing", cyc_a - t_rise, 2 * C_A);
        t_rise   = cyc_a;
        mosi_cap = {mosi_cap[14:0], bus_a.spi_mosi};
        rises++;
      end
      if (sck_fall && !bus_a.spi_ss) begin
        bus_a.spi_miso = (rises < 16) ? cur_resp[15 - rises] : 1'b0;
      end

      if (ss_rise) begin
        frames_a++;
        check("ss_low_cycles", low_len, SS_LOW_A);
        check("sck_rise_count", rises, 16);
        check("done_at_ss_rise", bus_a.done, 1'b1);
        check("miso_data", bus_a.miso_data, cur_resp);
        check("exp_q_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("mosi_frame", mosi_cap, exp_q.pop_front());
        bus_a.spi_miso = 1'b0;
      end
      if (busy_fall) begin
        check("busy_cycles", busy_len, BUSY_A);
        busy_len = 0;
      end
    end
    p_ss   = bus_a.spi_ss;
    p_sck  = bus_a.spi_sck;
    p_busy = bus_a.busy;
    p_mosi = bus_a.spi_mosi;
  end

  // ---------------- monitor, instance B (held request) ----------------
  int          cyc_b = 0, b_t_fall = 0, b_low = 0, b_starts = 0, b_frames = 0, b_dones = 0;
  logic        bp_ss = 1'b1, bp_sck = 1'b0;
  logic [15:0] b_cap = '0;
  logic [15:0] b_exp = '0;

  always @(posedge clk) begin
    #1;
    cyc_b++;
    if (!rst_b) begin
      if (bp_ss && !bus_b.spi_ss) begin
        if (b_starts > 0) check("b_frame_period", cyc_b - b_t_fall, PERIOD_B);
        b_t_fall = cyc_b;
        b_low    = 0;
        b_cap    = '0;
        b_starts++;
      end
      if (!bus_b.spi_ss) b_low++;
      if (!bp_sck && bus_b.spi_sck) b_cap = {b_cap[14:0], bus_b.spi_mosi};
      if (bus_b.done) b_dones++;
      if (!bp_ss && bus_b.spi_ss) begin
        b_frames++;
        check("b_ss_low_cycles", b_low, SS_LOW_B);
        check("b_mosi_frame", b_cap, b_exp);
        check("b_done", bus_b.done, 1'b1);
        check("b_miso_data", bus_b.miso_data, 16'h0000);
      end
    end
    bp_ss  = bus_b.spi_ss;
    bp_sck = bus_b.spi_sck;
  end

  // ---------------- driver tasks ----------------
  // Issues one request on A and waits until A is idle again. poke_at > 0
  // pulses a second (ignored) request that many cycles after acceptance.
  task automatic send_a(input logic [9:0] s, input logic [3:0] ch, input logic [15:0] resp,
                        input int extra_idle, input int poke_at);
    logic [15:0] f;
    f = frame_of(s, ch);
    exp_q.push_back(f);
    resp_q.push_back(resp);
    exp_frames_a++;
    bus_a.sample         = s;
    bus_a.sample_channel = ch;
    bus_a.new_sample     = 1'b1;
    @(negedge clk);
    bus_a.new_sample = 1'b0;
    check("accept_busy", bus_a.busy, 1'b1);
    check("accept_ss", bus_a.spi_ss, 1'b0);
    check("accept_mosi", bus_a.spi_mosi, f[15]);
    // Scramble inputs: the frame in flight must not see them.
    bus_a.sample         = 10'($urandom);
    bus_a.sample_channel = 4'($urandom);
    if (poke_at > 0) begin
      repeat (poke_at - 1) @(negedge clk);
      bus_a.new_sample = 1'b1;
      @(negedge clk);
      bus_a.new_sample = 1'b0;
      repeat (BUSY_A + extra_idle - poke_at) @(negedge clk);
    end else begin
      repeat (BUSY_A + extra_idle) @(negedge clk);
    end
  endtask

  // Starts a frame on A and resets it during bit 9.
  task automatic abort_a(input logic [9:0] s, input logic [3:0] ch);
    exp_q.push_back(frame_of(s, ch));
    resp_q.push_back(16'h1234);
    bus_a.sample         = s;
    bus_a.sample_channel = ch;
    bus_a.new_sample     = 1'b1;
    @(negedge clk);
    bus_a.new_sample = 1'b0;
    // Bit 9 sck high covers edges E0+1+C+18C .. +C-1 after acceptance.
    repeat (1 + C_A + 18 * C_A) @(negedge clk);
    check("abort_mid_frame_ss", bus_a.spi_ss, 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_ss", bus_a.spi_ss, 1'b1);
    check("abort_sck", bus_a.spi_sck, 1'b0);
    check("abort_busy", bus_a.busy, 1'b0);
    check("abort_done", bus_a.done, 1'b0);
    check("abort_miso_data", bus_a.miso_data, 16'h0000);
    void'(exp_q.pop_back());
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus_a.new_sample     = 1'b0;
    bus_a.sample         = '0;
    bus_a.sample_channel = '0;
    bus_b.new_sample     = 1'b0;
    bus_b.sample         = '0;
    bus_b.sample_channel = '0;
    bus_b.spi_miso       = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ss", bus_a.spi_ss, 1'b1);
    check("rst_sck", bus_a.spi_sck, 1'b0);
    check("rst_mosi", bus_a.spi_mosi, 1'b0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_done", bus_a.done, 1'b0);
    check("rst_miso_data", bus_a.miso_data, 16'h0000);
    check("rst_state", state_dbg_a, 2'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    send_a(10'h2A5, 4'h5, 16'hBEEF, 3, 0);
    send_a(10'h155, 4'hA, 16'h0F0F, 2, 10);
    abort_a(10'h0C3, 4'h7);
    send_a(10'h2A5, 4'h5, 16'hC001, 1, 0);
    for (int i = 0; i < 8; i++) begin
      send_a(10'($urandom), 4'($urandom), 16'($urandom), $urandom_range(0, 6), 0);
    end
    send_a(10'h3FF, 4'hF, 16'hFFFF, 20, 0);
    send_a(10'h000, 4'h0, 16'h0000, 20, 0);

    // Held request on B: frames must run back to back at the minimum period.
    bus_b.sample         = 10'h1C3;
    bus_b.sample_channel = 4'h9;
    b_exp                = frame_of(10'h1C3, 4'h9);
    bus_b.new_sample     = 1'b1;
    repeat (HELD_B * PERIOD_B) @(negedge clk);
    bus_b.new_sample = 1'b0;
    repeat (2 * PERIOD_B) @(negedge clk);

    check("a_frame_count", frames_a, exp_frames_a);
    check("a_done_count", dones_a, exp_frames_a);
    check("a_protocol_errors", proto_bad_a, 0);
    check("a_exp_q_left", exp_q.size(), 0);
    check("b_start_count", b_starts, HELD_B);
    check("b_frame_count", b_frames, HELD_B);
    check("b_done_count", b_dones, HELD_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
